port_rr_sched: RTL
==================

PORT_RR_SCHED -- requirements
Module: port_rr_sched

Interface
- REQ-001 SHALL have parameter NUM_PORTS, default 4: number of input FIFOs arbitrated (2..16).
- REQ-002 SHALL have parameter DATA_WIDTH, default 8: FIFO word width.
- REQ-003 SHALL have parameter TIMEOUT_CYC, default 64: stall limit used only under REQ-026.
- REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
- REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
- REQ-006 SHALL have port fifo_dout, input, NUM_PORTS*DATA_WIDTH: head word of each first-word-fall-through FIFO; port i is at [i*DATA_WIDTH +: DATA_WIDTH].
- REQ-007 SHALL have port fifo_eop, input, NUM_PORTS: head word of port i is the last word of its packet.
- REQ-008 SHALL have port fifo_empty, input, NUM_PORTS: FIFO i is empty.
- REQ-009 SHALL have port fifo_rd_en, output, NUM_PORTS: pop strobe for FIFO i; at most one bit high.
- REQ-010 SHALL have port wr_valid, output, 1: wr_data is valid this cycle.
- REQ-011 SHALL have port wr_ready, input, 1: downstream SRAM writer accepts the word.
- REQ-012 SHALL have port wr_data, output, DATA_WIDTH: forwarded word.
- REQ-013 SHALL have port wr_port, output, $clog2(NUM_PORTS): source port of wr_data.
- REQ-014 SHALL have port wr_eop, output, 1: wr_data is the last word of a packet.
- REQ-015 SHALL have port busy, output, 1: high in XFER state.

Function
- REQ-016 SHALL implement FSM states IDLE and XFER, plus ABORT when PKT_TIMEOUT_EN is defined.
- REQ-017 In IDLE, if any fifo_empty bit is low, SHALL select the first non-empty port in round-robin order starting at last_grant+1 (mod NUM_PORTS), register it as grant, and enter XFER on the next edge. Arbitration latency is 1 cycle.
- REQ-018 In IDLE, SHALL hold wr_valid=0 and fifo_rd_en=0.
- REQ-019 In XFER, wr_valid SHALL be ~fifo_empty[grant] (combinational); wr_data, wr_eop and wr_port SHALL mirror the head of FIFO grant.
- REQ-020 SHALL drive fifo_rd_en[grant] = wr_valid & wr_ready; all other bits are 0. A word transfers only when valid and ready are both high.
- REQ-021 On a transfer with wr_eop=1, SHALL set last_grant <= grant and return to IDLE. Packets from different ports never interleave.
- REQ-022 In XFER, an empty granted FIFO SHALL stall the transfer without releasing the grant; wr_valid stays 0.
- REQ-023 Once wr_valid is asserted, wr_data, wr_eop and wr_port SHALL stay stable until the word transfers.
- REQ-024 Round-robin pointer arithmetic SHALL wrap from NUM_PORTS-1 to 0. When only one port is non-empty, that port is granted regardless of last_grant.

Reset
- REQ-025 While rst_n=0, asynchronously: state=IDLE, grant=0, last_grant=NUM_PORTS-1 (so port 0 wins first), timeout counter=0, all outputs 0. A reset asserted mid-packet SHALL abandon the packet; no pop occurs during reset.

Configuration
- REQ-026 With macro PORT_RR_SCHED_TIMEOUT_EN defined:
  - SHALL add output pkt_timeout (1 bit).
  - SHALL count consecutive XFER cycles with fifo_empty[grant]=1.
  - On reaching TIMEOUT_CYC, SHALL enter ABORT for one cycle: pulse pkt_timeout=1 and set last_grant <= grant.
  - SHALL then return to IDLE.
  - The counter SHALL clear on any transfer or on leaving XFER.
- REQ-027 Without the macro, pkt_timeout, the counter and ABORT SHALL be absent, and stalls SHALL be unbounded.

Verification
- REQ-028 After reset, ports 0 and 2 each hold a 3-word packet, wr_ready=1 -> port 0 words on cycles 2-4, port 2 words on cycles 6-8, wr_eop on the 3rd word of each, wr_port 0 then 2.
- REQ-029 All 4 ports continuously non-empty with 1-word packets -> grant order 0,1,2,3,0,... with one IDLE cycle between packets.
- REQ-030 wr_ready toggles 1,0,1,0 during a 4-word packet -> no fifo_rd_en while wr_ready=0, 4 pops total, wr_data stable across stalls.
- REQ-031 Port 1 empties mid-packet while port 3 is non-empty -> port 3 not granted until port 1 delivers its eop word.
- REQ-032 rst_n pulsed low for 1 cycle mid-packet -> all outputs 0 immediately; next grant is port 0 if it is non-empty.
- REQ-033 With PORT_RR_SCHED_TIMEOUT_EN defined and TIMEOUT_CYC=8, the granted port stalls empty -> pkt_timeout pulses exactly once, 8 cycles after the stall begins, and the next packet comes from another port.

Source files
------------

// File: rtl/port_rr_sched.sv
// Round-robin packet scheduler: drains whole packets from NUM_PORTS FWFT FIFOs into one writer.
// Define PORT_RR_SCHED_TIMEOUT_EN to add the stall timeout (pkt_timeout output and ABORT state).
module port_rr_sched #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_dout,
    input  logic [NUM_PORTS-1:0]          fifo_eop,
    input  logic [NUM_PORTS-1:0]          fifo_empty,
    output logic [NUM_PORTS-1:0]          fifo_rd_en,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [$clog2(NUM_PORTS)-1:0]  wr_port,
    output logic                          wr_eop,
    output logic                          busy
`ifdef PORT_RR_SCHED_TIMEOUT_EN
    ,
    output logic                          pkt_timeout
`endif
);

    localparam int unsigned PW = $clog2(NUM_PORTS);

    if (NUM_PORTS < 2 || NUM_PORTS > 16 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("port_rr_sched: parameter out of range");
    end

`ifdef PORT_RR_SCHED_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, XFER, ABORT} state_t;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] stall_cnt_q, stall_cnt_d;
`else
    typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

    state_t        state_q, state_d;
    logic [PW-1:0] grant_q, grant_d;
    logic [PW-1:0] last_grant_q, last_grant_d;
    logic [PW-1:0] pick;
    logic [PW-1:0] cand;
    logic          found;
    logic          xfer;

    // First non-empty port scanning upward from last_grant+1, wrapping at NUM_PORTS.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = PW'((32'(last_grant_q) + i) % NUM_PORTS);
            if (!found && !fifo_empty[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        fifo_rd_en   = '0;
        wr_valid     = 1'b0;
        wr_data      = '0;
        wr_port      = '0;
        wr_eop       = 1'b0;
        busy         = 1'b0;
        xfer         = 1'b0;
`ifdef PORT_RR_SCHED_TIMEOUT_EN
        pkt_timeout  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                busy     = 1'b1;
                wr_valid = ~fifo_empty[grant_q];
                wr_data  = fifo_dout[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                wr_eop   = fifo_eop[grant_q];
                wr_port  = grant_q;
                xfer     = wr_valid & wr_ready;
                fifo_rd_en[grant_q] = xfer;
                if (xfer && wr_eop) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
`ifdef PORT_RR_SCHED_TIMEOUT_EN
                else if (!wr_valid && stall_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = ABORT;
                end
`endif
            end
`ifdef PORT_RR_SCHED_TIMEOUT_EN
            ABORT: begin
                pkt_timeout  = 1'b1;
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

`ifdef PORT_RR_SCHED_TIMEOUT_EN
    // Counts consecutive empty cycles while the grant is held; anything else clears it.
    always_comb begin
        if (state_q == XFER && state_d == XFER && fifo_empty[grant_q])
            stall_cnt_d = stall_cnt_q + 1'b1;
        else
            stall_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= PW'(NUM_PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
